// File: rtl/servant_spi_slave_sync.sv
// SPI mode-0 slave bridging the servant RAM as an FRAM-style serial memory.
// All logic runs on i_clk; SCK/CS/MOSI are oversampled through synchronisers.
module servant_spi_slave_sync #(
    parameter int unsigned ADDR_WIDTH  = 18,
    parameter int unsigned ADDR_BYTES  = 3,
    parameter logic [31:0] DEVICE_ID   = 32'h047F4803,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  spi_sck,
    input  logic                  spi_cs,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [7:0]            o_ram_wdata,
    output logic                  o_ram_we,
    output logic                  o_ram_req,
    input  logic                  i_ram_ack,
    input  logic [7:0]            i_ram_rdata,
    output logic                  o_underrun
);

    localparam int unsigned BC_W = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

    localparam logic [7:0] OP_WRSR  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_FAST  = 8'h0B;
    localparam logic [7:0] OP_RDID  = 8'h9F;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_READ,
        S_WRITE,
        S_STATUS,
        S_ID,
        S_WRSR,
        S_IGNORE
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q, cs_prev_d;

    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [BC_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [7:0]            rx_q, rx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            op_q, op_d;
    logic                  wel_q, wel_d;
    logic [5:0]            sr_q, sr_d;
    logic                  wr_cmd_q, wr_cmd_d;
    logic [7:0]            tx_q, tx_d;
    logic [1:0]            id_idx_q, id_idx_d;
    logic [7:0]            buf_q, buf_d;
    logic                  buf_vld_q, buf_vld_d;
    logic                  req_q, req_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  underrun_q, underrun_d;

    logic                  sck_s, cs_s, mosi_s;
    logic                  sck_rise, sck_fall, cs_rise, cs_fall;
    logic                  active;
    logic                  byte_end;
    logic                  addr_last;
    logic                  ack_rd;
    logic [7:0]            rx_byte;
    logic [7:0]            status_byte;
    logic [7:0]            id_byte;
    logic [ADDR_WIDTH-1:0] addr_sh;
    logic                  do_rd;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Synchronised pin views and edge events
    assign sck_s       = sck_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise    = sck_s & ~sck_prev_q;
    assign sck_fall    = ~sck_s & sck_prev_q;
    assign cs_rise     = cs_s & ~cs_prev_q;
    assign cs_fall     = ~cs_s & cs_prev_q;
    assign active      = (state_q != S_IDLE) && !cs_rise && !cs_fall;
    assign byte_end    = active && sck_rise && (bit_cnt_q == 3'd7);
    assign addr_last   = (byte_cnt_q == BC_W'(ADDR_BYTES - 1));
    assign ack_rd      = req_q & i_ram_ack & ~we_q;
    assign rx_byte     = {rx_q[6:0], mosi_s};
    assign status_byte = {sr_q, wel_q, 1'b0};
    assign addr_sh     = {addr_q[ADDR_WIDTH-2:0], mosi_s};

    // Device ID byte selected by the rotating index
    always_comb begin
        case (id_idx_q)
            2'd0:    id_byte = DEVICE_ID[31:24];
            2'd1:    id_byte = DEVICE_ID[23:16];
            2'd2:    id_byte = DEVICE_ID[15:8];
            default: id_byte = DEVICE_ID[7:0];
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state: CS edges dominate, otherwise advance on byte boundaries
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = S_IDLE;
        end else if (cs_fall) begin
            state_d = S_CMD;
        end else if (byte_end) begin
            case (state_q)
                S_CMD: begin
                    case (rx_byte)
                        OP_RDSR:                    state_d = S_STATUS;
                        OP_WRSR:                    state_d = S_WRSR;
                        OP_RDID:                    state_d = S_ID;
                        OP_READ, OP_FAST, OP_WRITE: state_d = S_ADDR;
                        default:                    state_d = S_IGNORE;
                    endcase
                end
                S_ADDR: begin
                    if (addr_last) begin
                        if (op_q == OP_READ)      state_d = S_READ;
                        else if (op_q == OP_FAST) state_d = S_DUMMY;
                        else                      state_d = S_WRITE;
                    end
                end
                S_DUMMY: state_d = S_READ;
                S_WRSR:  state_d = S_IGNORE;
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath and output next values driven by the current state and pin events
    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        rx_d        = rx_q;
        addr_d      = addr_q;
        op_d        = op_q;
        wel_d       = wel_q;
        sr_d        = sr_q;
        wr_cmd_d    = wr_cmd_q;
        tx_d        = tx_q;
        id_idx_d    = id_idx_q;
        buf_d       = buf_q;
        buf_vld_d   = buf_vld_q;
        req_d       = req_q;
        we_d        = we_q;
        ram_addr_d  = ram_addr_q;
        wdata_d     = wdata_q;
        underrun_d  = underrun_q;
        do_rd       = 1'b0;
        rd_addr     = addr_q;

        // A completed request drops req; read data lands in the prefetch buffer
        if (req_q && i_ram_ack) begin
            req_d = 1'b0;
            if (!we_q) begin
                buf_d     = i_ram_rdata;
                buf_vld_d = 1'b1;
            end
        end

        if (cs_fall) begin
            bit_cnt_d  = 3'd0;
            byte_cnt_d = '0;
            tx_d       = 8'h00;
            id_idx_d   = 2'd0;
            buf_vld_d  = 1'b0;
            wr_cmd_d   = 1'b0;
        end else if (cs_rise) begin
            tx_d = 8'h00;
            if (wr_cmd_q) wel_d = 1'b0;
        end else if (active && sck_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            case (state_q)
                S_CMD: begin
                    if (bit_cnt_q == 3'd7) begin
                        op_d = rx_byte;
                        case (rx_byte)
                            OP_WREN:           wel_d    = 1'b1;
                            OP_WRDI:           wel_d    = 1'b0;
                            OP_WRSR, OP_WRITE: wr_cmd_d = 1'b1;
                            default:           wel_d    = wel_q;
                        endcase
                    end
                end
                S_ADDR: begin
                    addr_d = addr_sh;
                    if (bit_cnt_q == 3'd7) begin
                        byte_cnt_d = byte_cnt_q + BC_W'(1);
                        if (addr_last && (op_q == OP_READ)) begin
                            do_rd   = 1'b1;
                            rd_addr = addr_sh;
                        end
                    end
                end
                S_DUMMY: begin
                    if (bit_cnt_q == 3'd7) do_rd = 1'b1;
                end
                S_READ: begin
                    if (bit_cnt_q == 3'd0) do_rd = 1'b1;
                end
                S_WRITE: begin
                    if (bit_cnt_q == 3'd7) begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                        if (wel_q && !req_q) begin
                            req_d      = 1'b1;
                            we_d       = 1'b1;
                            ram_addr_d = addr_q;
                            wdata_d    = rx_byte;
                        end
                    end
                end
                S_WRSR: begin
                    if ((bit_cnt_q == 3'd7) && wel_q) sr_d = rx_byte[7:2];
                end
                default: rx_d = rx_byte;
            endcase
        end else if (active && sck_fall) begin
            if (bit_cnt_q == 3'd0) begin
                case (state_q)
                    S_STATUS: tx_d = status_byte;
                    S_ID: begin
                        tx_d     = id_byte;
                        id_idx_d = id_idx_q + 2'd1;
                    end
                    S_READ: begin
                        buf_vld_d = 1'b0;
                        if (buf_vld_q) begin
                            tx_d = buf_q;
                        end else if (ack_rd) begin
                            tx_d = i_ram_rdata;
                        end else begin
                            tx_d       = 8'hFF;
                            underrun_d = 1'b1;
                        end
                    end
                    default: tx_d = 8'h00;
                endcase
            end else begin
                tx_d = {tx_q[6:0], 1'b0};
            end
        end

        // Read issue: address always advances, request only if the port is free
        if (do_rd) begin
            addr_d = rd_addr + ADDR_WIDTH'(1);
            if (!req_q) begin
                req_d      = 1'b1;
                we_d       = 1'b0;
                ram_addr_d = rd_addr;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= '0;
            rx_q        <= 8'h00;
            addr_q      <= '0;
            op_q        <= 8'h00;
            wel_q       <= 1'b0;
            sr_q        <= 6'h00;
            wr_cmd_q    <= 1'b0;
            tx_q        <= 8'h00;
            id_idx_q    <= 2'd0;
            buf_q       <= 8'h00;
            buf_vld_q   <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            ram_addr_q  <= '0;
            wdata_q     <= 8'h00;
            underrun_q  <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            cs_prev_q   <= cs_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_q        <= rx_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            wel_q       <= wel_d;
            sr_q        <= sr_d;
            wr_cmd_q    <= wr_cmd_d;
            tx_q        <= tx_d;
            id_idx_q    <= id_idx_d;
            buf_q       <= buf_d;
            buf_vld_q   <= buf_vld_d;
            req_q       <= req_d;
            we_q        <= we_d;
            ram_addr_q  <= ram_addr_d;
            wdata_q     <= wdata_d;
            underrun_q  <= underrun_d;
        end
    end

    assign spi_miso    = tx_q[7];
    assign o_ram_addr  = ram_addr_q;
    assign o_ram_wdata = wdata_q;
    assign o_ram_we    = we_q;
    assign o_ram_req   = req_q;
    assign o_underrun  = underrun_q;

endmodule
